nios2_jtag_scan_master: RTL

Initiator side of the virtual-JTAG link that feeds the Nios II on-chip debug module. It generates the tck, tdi, ir_in and virtual-state strobes (uir/cdr/sdr/udr/rti) that the debug module's tck-domain logic consumes, and captures tdo. A command interface accepts one IR/DR scan at a time and returns the captured DR. It drives the debug module from fabric logic, such as a bench host model or an on-chip debug sequencer, without an external JTAG cable.

---
 rtl/nios2_jtag_pkg.sv | 27 ++
 rtl/nios2_jtag_tck_gen.sv | 39 +++
 rtl/nios2_jtag_scan_master.sv | 137 +++++++++++++
 3 files changed

// File: rtl/nios2_jtag_pkg.sv
// Shared types and constants for the virtual-JTAG scan master that drives the
// Nios II on-chip debug module.
package nios2_jtag_pkg;

    localparam int unsigned DEFAULT_DR_WIDTH = 38;
    localparam int unsigned DEFAULT_IR_WIDTH = 2;

    localparam logic [DEFAULT_IR_WIDTH-1:0] IR_OCIMEM    = 2'd0;
    localparam logic [DEFAULT_IR_WIDTH-1:0] IR_TRACEMEM  = 2'd1;
    localparam logic [DEFAULT_IR_WIDTH-1:0] IR_BREAK     = 2'd2;
    localparam logic [DEFAULT_IR_WIDTH-1:0] IR_TRACECTRL = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_UIR  = 3'd1,
        ST_CDR  = 3'd2,
        ST_SDR  = 3'd3,
        ST_UDR  = 3'd4,
        ST_RSP  = 3'd5
    } scan_state_e;

    // tck only toggles while a virtual-JTAG step is in progress
    function automatic logic tck_active(input scan_state_e s);
        return (s == ST_UIR) || (s == ST_CDR) || (s == ST_SDR) || (s == ST_UDR);
    endfunction

endpackage

// File: rtl/nios2_jtag_tck_gen.sv
// Scan clock generator: divides clk into a tck of 2*TCK_DIV cycles while enabled
// and flags the clk edges on which tck rises and falls.
module nios2_jtag_tck_gen #(
    parameter int unsigned TCK_DIV = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    output logic tck,
    output logic rise_c,
    output logic fall_c
);

    localparam int unsigned CNT_W = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;

    logic [CNT_W-1:0] cnt_q;
    logic             wrap_c;

    assign wrap_c = en && (cnt_q == CNT_W'(TCK_DIV - 1));
    assign rise_c = wrap_c && !tck;
    assign fall_c = wrap_c && tck;

    // Disabling parks tck low with the divider at zero so each step starts a fresh period
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
            tck   <= 1'b0;
        end else if (!en) begin
            cnt_q <= '0;
            tck   <= 1'b0;
        end else if (wrap_c) begin
            cnt_q <= '0;
            tck   <= ~tck;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/nios2_jtag_scan_master.sv
// Fabric-side virtual-JTAG initiator: runs one IR/DR scan per command against the
// debug module's tck-domain logic and returns the captured DR.
module nios2_jtag_scan_master
    import nios2_jtag_pkg::*;
#(
    parameter int unsigned DR_WIDTH = DEFAULT_DR_WIDTH,
    parameter int unsigned IR_WIDTH = DEFAULT_IR_WIDTH,
    parameter int unsigned TCK_DIV  = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_update_ir,
    input  logic [IR_WIDTH-1:0] cmd_ir,
    input  logic [DR_WIDTH-1:0] cmd_dr,
    output logic                rsp_valid,
    output logic [DR_WIDTH-1:0] rsp_dr,
    output logic                vji_tck,
    output logic                vji_tdi,
    input  logic                vji_tdo,
    output logic [IR_WIDTH-1:0] vji_ir_in,
    output logic                vji_uir,
    output logic                vji_cdr,
    output logic                vji_sdr,
    output logic                vji_udr,
    output logic                vji_rti,
    output logic                busy
);

    localparam int unsigned BIT_W = $clog2(DR_WIDTH + 1);

    scan_state_e         state_q, state_d;
    logic [DR_WIDTH-1:0] shift_q;
    logic [DR_WIDTH-1:0] cap_q;
    logic [BIT_W-1:0]    bit_cnt_q;
    logic                rise_c, fall_c;
    logic                last_bit_c;

    assign last_bit_c = (bit_cnt_q == BIT_W'(DR_WIDTH - 1));

    nios2_jtag_tck_gen #(
        .TCK_DIV (TCK_DIV)
    ) u_tck_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (tck_active(state_q)),
        .tck     (vji_tck),
        .rise_c  (rise_c),
        .fall_c  (fall_c)
    );

    // Next state: every scan step ends on a tck falling edge
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (cmd_valid) state_d = cmd_update_ir ? ST_UIR : ST_CDR;
            ST_UIR:  if (fall_c) state_d = ST_CDR;
            ST_CDR:  if (fall_c) state_d = ST_SDR;
            ST_SDR:  if (fall_c && last_bit_c) state_d = ST_UDR;
            ST_UDR:  if (fall_c) state_d = ST_RSP;
            ST_RSP:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State register plus strobes decoded from the next state so they align with it
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            rsp_valid <= 1'b0;
            vji_uir   <= 1'b0;
            vji_cdr   <= 1'b0;
            vji_sdr   <= 1'b0;
            vji_udr   <= 1'b0;
            vji_rti   <= 1'b1;
        end else begin
            state_q   <= state_d;
            cmd_ready <= (state_d == ST_IDLE);
            busy      <= (state_d != ST_IDLE);
            rsp_valid <= (state_d == ST_RSP);
            vji_uir   <= (state_d == ST_UIR);
            vji_cdr   <= (state_d == ST_CDR);
            vji_sdr   <= (state_d == ST_SDR);
            vji_udr   <= (state_d == ST_UDR);
            vji_rti   <= (state_d == ST_IDLE);
        end
    end

    // Shift/capture datapath: tdi advances on tck fall, tdo is taken on tck rise
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shift_q   <= '0;
            cap_q     <= '0;
            bit_cnt_q <= '0;
            vji_tdi   <= 1'b0;
            vji_ir_in <= '0;
            rsp_dr    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        shift_q   <= cmd_dr;
                        cap_q     <= '0;
                        bit_cnt_q <= '0;
                        if (cmd_update_ir) vji_ir_in <= cmd_ir;
                    end
                end
                ST_CDR: begin
                    if (fall_c) begin
                        vji_tdi <= shift_q[0];
                        shift_q <= shift_q >> 1;
                    end
                end
                ST_SDR: begin
                    if (rise_c) cap_q <= DR_WIDTH'({vji_tdo, cap_q} >> 1);
                    if (fall_c) begin
                        if (last_bit_c) begin
                            vji_tdi <= 1'b0;
                        end else begin
                            vji_tdi   <= shift_q[0];
                            shift_q   <= shift_q >> 1;
                            bit_cnt_q <= bit_cnt_q + BIT_W'(1);
                        end
                    end
                end
                ST_UDR: begin
                    if (fall_c) rsp_dr <= cap_q;
                end
                default: ;
            endcase
        end
    end

endmodule
